clk_div_monitor: RTL and testbench

Clock-health monitor placed directly downstream of the clk_div6 divider. It samples the divided clock in the fast `clk` domain, emits one-cycle rise/fall strobes, and measures each half-period in `clk` cycles. It declares lock after a run of correct half-periods and raises a sticky fault on a wrong or missing edge. Control logic uses it as the divided-clock-valid indication and as an error counter.

---
 rtl/clk_div_monitor.sv | 146 ++++++++++++++
 tb/tb_clk_div_monitor.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor.sv
// Divided-clock health monitor: edge strobes, half-period measurement,
// lock tracking and a sticky fault with a saturating error counter.
module clk_div_monitor #(
    parameter int EXP_HALF = 3,
    parameter int LOCK_CNT = 4,
    parameter int CW       = 8,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_in,
    input  logic             clr_err,
    output logic             edge_rise,
    output logic             edge_fall,
    output logic [CW-1:0]    half_period,
    output logic             locked,
    output logic             fault,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0]    CNT_MAX  = '1;
    localparam logic [CW-1:0]    EXP      = CW'(EXP_HALF);
    localparam logic [GW-1:0]    GOOD_TOP = GW'(LOCK_CNT - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACQ,
        S_LOCKED,
        S_FAULT
    } state_e;

    state_e           state_q, state_d;
    logic             div_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    hp_q, hp_d;
    logic [GW-1:0]    good_q, good_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             rise_q, fall_q;

    logic             rise, fall, edge_det;
    logic [CW-1:0]    meas;
    logic             meas_ok;
    logic             timeout;
    logic             err_ev;

    assign rise     = div_in & ~div_q;
    assign fall     = ~div_in & div_q;
    assign edge_det = rise | fall;

    // Measurement includes the edge cycle itself, hence cnt+1.
    assign meas    = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    assign meas_ok = (meas == EXP);
    assign timeout = ~edge_det && (cnt_q >= EXP);

    always_comb begin
        cnt_d = cnt_q;
        hp_d  = hp_q;
        if (edge_det) begin
            cnt_d = '0;
            hp_d  = meas;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_ev  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (edge_det) begin
                    state_d = S_ACQ;
                    good_d  = '0;
                end
            end
            S_ACQ: begin
                if (edge_det) begin
                    if (meas_ok) begin
                        good_d = good_q + 1'b1;
                        if (good_q == GOOD_TOP) begin
                            state_d = S_LOCKED;
                        end
                    end else begin
                        good_d = '0;
                        err_ev = 1'b1;
                    end
                end
            end
            S_LOCKED: begin
                if ((edge_det && !meas_ok) || timeout) begin
                    state_d = S_FAULT;
                    err_ev  = 1'b1;
                end
            end
            S_FAULT: begin
                if (clr_err) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A clear in the same cycle as an error wins; the error is dropped.
    always_comb begin
        err_d = err_q;
        if (clr_err) begin
            err_d = '0;
        end else if (err_ev && (err_q != ERR_MAX)) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            div_q   <= 1'b0;
            cnt_q   <= '0;
            hp_q    <= '0;
            good_q  <= '0;
            err_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_in;
            cnt_q   <= cnt_d;
            hp_q    <= hp_d;
            good_q  <= good_d;
            err_q   <= err_d;
            rise_q  <= rise;
            fall_q  <= fall;
        end
    end

    assign edge_rise   = rise_q;
    assign edge_fall   = fall_q;
    assign half_period = hp_q;
    assign locked      = (state_q == S_LOCKED);
    assign fault       = (state_q == S_FAULT);
    assign err_cnt     = err_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: directed scenarios plus random half-periods,
// checked every cycle against an event-level reference model.
module tb_clk_div_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       div_in;
    logic       clr_err;

    logic       r8, f8, l8, fl8;
    logic [7:0] hp8, e8;
    logic       r4, f4, l4, fl4;
    logic [7:0] hp4;
    logic [3:0] e4;

    int total = 0;
    int bad   = 0;

    clk_div_monitor u8 (
        .clk(clk), .reset(reset), .div_in(div_in), .clr_err(clr_err),
        .edge_rise(r8), .edge_fall(f8), .half_period(hp8),
        .locked(l8), .fault(fl8), .err_cnt(e8)
    );

    clk_div_monitor #(.ERR_W(4)) u4 (
        .clk(clk), .reset(reset), .div_in(div_in), .clr_err(clr_err),
        .edge_rise(r4), .edge_fall(f4), .half_period(hp4),
        .locked(l4), .fault(fl4), .err_cnt(e4)
    );

    always #5 clk = ~clk;

    localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2, M_FAULT = 3;
    int m_lvl, m_since, m_st, m_good, m_err8, m_err4, m_hp;
    bit m_rise, m_fall;
    bit cur;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lvl = 0; m_since = 0; m_st = M_IDLE; m_good = 0;
        m_err8 = 0; m_err4 = 0; m_hp = 0; m_rise = 0; m_fall = 0;
    endtask

    // Outputs expected after one clk edge that sampled div=d, clr=c.
    task automatic model_step(input bit d, input bit c);
        bit edge_seen;
        bit ev;
        int meas;
        edge_seen = (d != m_lvl[0]);
        meas = (m_since + 1 > 255) ? 255 : m_since + 1;
        m_rise = d && !m_lvl[0];
        m_fall = !d && m_lvl[0];
        ev = 0;
        case (m_st)
            M_IDLE: if (edge_seen) begin m_st = M_ACQ; m_good = 0; end
            M_ACQ: if (edge_seen) begin
                if (meas == 3) begin
                    m_good++;
                    if (m_good == 4) m_st = M_LOCK;
                end else begin
                    m_good = 0; ev = 1;
                end
            end
            M_LOCK: if ((edge_seen && meas != 3) || (!edge_seen && m_since >= 3)) begin
                m_st = M_FAULT; ev = 1;
            end
            default: if (c) m_st = M_IDLE;
        endcase
        if (edge_seen) begin
            m_hp = meas; m_since = 0;
        end else if (m_since < 255) begin
            m_since++;
        end
        if (c) begin
            m_err8 = 0; m_err4 = 0;
        end else if (ev) begin
            m_err8 = (m_err8 < 255) ? m_err8 + 1 : 255;
            m_err4 = (m_err4 < 15) ? m_err4 + 1 : 15;
        end
        m_lvl = d;
    endtask

    task automatic check_all();
        chk("rise8", r8, m_rise);
        chk("fall8", f8, m_fall);
        chk("hp8", hp8, m_hp);
        chk("lock8", l8, m_st == M_LOCK);
        chk("fault8", fl8, m_st == M_FAULT);
        chk("err8", e8, m_err8);
        chk("rise4", r4, m_rise);
        chk("fall4", f4, m_fall);
        chk("lock4", l4, m_st == M_LOCK);
        chk("fault4", fl4, m_st == M_FAULT);
        chk("err4", e4, m_err4);
    endtask

    task automatic cyc(input bit d, input bit c);
        div_in  = d;
        clr_err = c;
        @(posedge clk);
        model_step(d, c);
        #1;
        check_all();
        clr_err = 1'b0;
    endtask

    task automatic half(input int n, input bit c = 1'b0);
        cur = ~cur;
        for (int i = 0; i < n; i++) cyc(cur, (i == 0) ? c : 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rise"}, r8, 0);
        chk({tag, "_fall"}, f8, 0);
        chk({tag, "_hp"}, hp8, 0);
        chk({tag, "_lock"}, l8, 0);
        chk({tag, "_fault"}, fl8, 0);
        chk({tag, "_err"}, e8, 0);
        chk({tag, "_err4"}, e4, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0; div_in = 1'b0; clr_err = 1'b0; cur = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b1;
    endtask

    initial begin
        int picks[7];
        picks = '{2, 3, 3, 3, 3, 4, 7};

        // nominal lock
        do_reset();
        repeat (4) half(3);
        chk("nom_not_yet", l8, 0);
        cur = ~cur;
        cyc(cur, 0);
        chk("nom_lock5", l8, 1);
        chk("nom_rise5", r8, 1);
        chk("nom_hp", hp8, 3);
        chk("nom_err", e8, 0);
        cyc(cur, 0);
        cyc(cur, 0);

        // stuck clock: last edge at t, fault after t+4
        cyc(cur, 0);
        chk("stuck_t3", fl8, 0);
        cyc(cur, 0);
        chk("stuck_fault", fl8, 1);
        chk("stuck_unlock", l8, 0);
        chk("stuck_err", e8, 1);
        repeat (5) cyc(cur, 0);
        chk("stuck_err_hold", e8, 1);
        cyc(cur, 1);
        chk("clr_fault", fl8, 0);
        chk("clr_err", e8, 0);
        repeat (4) half(3);
        chk("relock_not_yet", l8, 0);
        half(3);
        chk("relock", l8, 1);

        // wrong ratio
        do_reset();
        repeat (20) half(4);
        chk("ratio_hp", hp8, 4);
        chk("ratio_lock", l8, 0);
        chk("ratio_err8", e8, 19);
        chk("ratio_err4", e4, 15);

        // recovery in ACQ
        do_reset();
        half(3); half(3); half(2); half(3);
        chk("acq_err", e8, 1);
        half(3); half(3); half(3);
        chk("acq_not_yet", l8, 0);
        half(3);
        chk("acq_lock", l8, 1);
        chk("acq_err_end", e8, 1);

        // clr_err together with a bad edge while locked
        do_reset();
        half(3); half(2); half(3); half(3); half(3); half(3); half(3);
        chk("sim_lock", l8, 1);
        chk("sim_err1", e8, 1);
        half(2);
        cur = ~cur;
        cyc(cur, 1);
        chk("sim_fault", fl8, 1);
        chk("sim_err0", e8, 0);
        cyc(cur, 0);
        half(2); half(5); half(3);
        chk("sim_fault_err", e8, 0);
        chk("sim_sticky", fl8, 1);
        cyc(cur, 1);
        chk("sim_exit", fl8, 0);

        // asynchronous reset mid half-period
        do_reset();
        half(3); half(2); half(2); half(3); half(3); half(3); half(3);
        cur = ~cur;
        cyc(cur, 0);
        chk("mid_lock", l8, 1);
        chk("mid_err2", e8, 2);
        cyc(cur, 0);
        #2;
        reset = 1'b0;
        #1;
        check_zero("mid");
        do_reset();

        // random half-periods with sporadic clears
        for (int i = 0; i < 120; i++) begin
            half(picks[$urandom_range(0, 6)], ($urandom_range(0, 11) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
